// File: rtl/light_sequencer.sv
// Light-latch sequencer: initialises every road to red, then grants green round-robin
// and walks the granted road through green, yellow, red and an all-red clear.

module light_sequencer_chk #(
  parameter int roads       = 4,
  parameter int count_max   = 15,
  parameter int green_time  = 8,
  parameter int yellow_time = 3,
  parameter int clear_time  = 2
) (
  input logic                             clk,
  input logic                             reset,
  input logic                             light_valid,
  input logic [$clog2(count_max+1)-1:0]   timer
);

  if (roads < 2) begin : g_bad_roads
    $error("light_sequencer: roads must be at least 2");
  end
  if (green_time < 2 || green_time > count_max) begin : g_bad_green
    $error("light_sequencer: green_time must lie in 2..count_max");
  end
  if (yellow_time < 2 || yellow_time > count_max) begin : g_bad_yellow
    $error("light_sequencer: yellow_time must lie in 2..count_max");
  end
  if (clear_time < 2 || clear_time > count_max) begin : g_bad_clear
    $error("light_sequencer: clear_time must lie in 2..count_max");
  end

  // The latch needs a strobe-free cycle after every commit.
  a_pulse_gap: assert property (@(posedge clk) disable iff (reset)
    !light_valid |=> light_valid);

  a_timer_range: assert property (@(posedge clk)
    int'(timer) <= count_max);

endmodule

module light_sequencer #(
  parameter int roads       = 4,
  parameter int count_max   = 15,
  parameter int green_time  = 8,
  parameter int yellow_time = 3,
  parameter int clear_time  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [roads-1:0]          req,
  output logic [2:0]                light_out,
  output logic [$clog2(roads)-1:0]  road,
  output logic                      light_valid,
  output logic [2:0]                state,
  output logic [$clog2(roads)-1:0]  active_road
);

  localparam int RW = $clog2(roads);
  localparam int TW = $clog2(count_max + 1);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_GREEN  = 3'd2;
  localparam logic [2:0] ST_YELLOW = 3'd3;
  localparam logic [2:0] ST_CLEAR  = 3'd4;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  localparam logic [TW-1:0] GREEN_LOAD  = TW'(green_time - 1);
  localparam logic [TW-1:0] YELLOW_LOAD = TW'(yellow_time - 1);
  localparam logic [TW-1:0] CLEAR_LOAD  = TW'(clear_time - 1);
  localparam logic [RW-1:0] LAST_ROAD   = RW'(roads - 1);

  logic [2:0]    state_q,       state_d;
  logic          light_valid_q, light_valid_d;
  logic [RW-1:0] road_q,        road_d;
  logic [2:0]    light_out_q,   light_out_d;
  logic [RW-1:0] active_q,      active_d;
  logic [RW-1:0] last_q,        last_d;
  logic [TW-1:0] timer_q,       timer_d;
  logic [RW-1:0] init_road_q,   init_road_d;

  logic [RW-1:0] grant_s;
  logic          other_req_s;
  logic          expired_s;

  // First requesting road strictly after the previous grant, wrapping around.
  function automatic logic [RW-1:0] rr_pick(input logic [roads-1:0] r,
                                            input logic [RW-1:0]    last);
    logic [RW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= roads; i++) begin
      idx = (int'(last) + i) % roads;
      if (!found && r[idx]) begin
        pick  = RW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [roads-1:0] road_mask(input logic [RW-1:0] a);
    logic [roads-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

  always_comb begin
    grant_s     = rr_pick(req, last_q);
    other_req_s = |(req & ~road_mask(active_q));
    expired_s   = (timer_q == '0);

    state_d       = state_q;
    light_valid_d = 1'b1;
    road_d        = road_q;
    light_out_d   = light_out_q;
    active_d      = active_q;
    last_d        = last_q;
    timer_d       = expired_s ? timer_q : timer_q - TW'(1);
    init_road_d   = init_road_q;

    case (state_q)
      ST_INIT: begin
        // Alternate pulse / gap cycles so each red commit is two cycles apart.
        if (light_valid_q) begin
          light_valid_d = 1'b0;
          road_d        = init_road_q;
          light_out_d   = LIGHT_RED;
        end else if (init_road_q == LAST_ROAD) begin
          state_d = ST_IDLE;
        end else begin
          init_road_d = init_road_q + RW'(1);
        end
      end
      ST_IDLE: begin
        if (req != '0) begin
          light_valid_d = 1'b0;
          road_d        = grant_s;
          light_out_d   = LIGHT_GREEN;
          active_d      = grant_s;
          last_d        = grant_s;
          timer_d       = GREEN_LOAD;
          state_d       = ST_GREEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GREEN: begin
        if (!expired_s) begin
          state_d = ST_GREEN;
        end else if (other_req_s) begin
          light_valid_d = 1'b0;
          road_d        = active_q;
          light_out_d   = LIGHT_YELLOW;
          timer_d       = YELLOW_LOAD;
          state_d       = ST_YELLOW;
        end else begin
          timer_d = GREEN_LOAD;
        end
      end
      ST_YELLOW: begin
        if (expired_s) begin
          light_valid_d = 1'b0;
          road_d        = active_q;
          light_out_d   = LIGHT_RED;
          timer_d       = CLEAR_LOAD;
          state_d       = ST_CLEAR;
        end else begin
          state_d = ST_YELLOW;
        end
      end
      ST_CLEAR: begin
        if (!expired_s) begin
          state_d = ST_CLEAR;
        end else if (req != '0) begin
          light_valid_d = 1'b0;
          road_d        = grant_s;
          light_out_d   = LIGHT_GREEN;
          active_d      = grant_s;
          last_d        = grant_s;
          timer_d       = GREEN_LOAD;
          state_d       = ST_GREEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      light_valid_q <= 1'b1;
      road_q        <= '0;
      light_out_q   <= LIGHT_RED;
      active_q      <= '0;
      last_q        <= LAST_ROAD;
      timer_q       <= '0;
      init_road_q   <= '0;
    end else begin
      state_q       <= state_d;
      light_valid_q <= light_valid_d;
      road_q        <= road_d;
      light_out_q   <= light_out_d;
      active_q      <= active_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      init_road_q   <= init_road_d;
    end
  end

  assign light_out   = light_out_q;
  assign road        = road_q;
  assign light_valid = light_valid_q;
  assign state       = state_q;
  assign active_road = active_q;

  light_sequencer_chk #(
    .roads       (roads),
    .count_max   (count_max),
    .green_time  (green_time),
    .yellow_time (yellow_time),
    .clear_time  (clear_time)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .light_valid (light_valid_q),
    .timer       (timer_q)
  );

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: directed vector table, then random requests and resets
// compared cycle by cycle with a deadline-based reference model.

module tb_light_sequencer;

  localparam int ROADS = 4;
  localparam int GT    = 8;
  localparam int YT    = 3;
  localparam int CT    = 2;

  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [2:0] light_out;
  logic [1:0] road;
  logic       light_valid;
  logic [2:0] state;
  logic [1:0] active_road;

  int checks = 0;
  int passes = 0;

  light_sequencer #(
    .roads(ROADS), .count_max(15), .green_time(GT), .yellow_time(YT), .clear_time(CT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .light_out(light_out), .road(road),
    .light_valid(light_valid), .state(state), .active_road(active_road)
  );

  always #5 clk = ~clk;

  // Reference model: phases end at absolute cycle deadlines.
  int         edge_n = 0;
  int         init_base = 0;
  int         deadline = 0;
  int         m_state = 0;
  logic       m_lv = 1'b1;
  int         m_road = 0;
  logic [2:0] m_light = RED;
  int         m_active = 0;
  int         m_last = ROADS - 1;

  task automatic pulse(input int r, input logic [2:0] l);
    m_lv    = 1'b0;
    m_road  = r;
    m_light = l;
  endtask

  task automatic grant();
    int pick;
    pick = m_last;
    for (int i = ROADS; i >= 1; i--) begin
      if (req[(m_last + i) % ROADS]) pick = (m_last + i) % ROADS;
    end
    pulse(pick, GRN);
    m_active = pick;
    m_last   = pick;
    deadline = edge_n + GT;
    m_state  = 2;
  endtask

  task automatic model_edge();
    int k;
    edge_n++;
    if (reset) begin
      m_state = 0; m_lv = 1'b1; m_road = 0; m_light = RED;
      m_active = 0; m_last = ROADS - 1; init_base = edge_n + 1;
    end else begin
      m_lv = 1'b1;
      case (m_state)
        0: begin
          k = edge_n - init_base;
          if (k % 2 == 0 && k / 2 < ROADS) pulse(k / 2, RED);
          else if (k == 2 * ROADS - 1) m_state = 1;
        end
        1: if (req != 4'b0000) grant();
        2: if (edge_n == deadline) begin
             if ((req & ~(4'b0001 << m_active)) != 4'b0000) begin
               pulse(m_active, YEL); deadline = edge_n + YT; m_state = 3;
             end else begin
               deadline = edge_n + GT;
             end
           end
        3: if (edge_n == deadline) begin
             pulse(m_active, RED); deadline = edge_n + CT; m_state = 4;
           end
        4: if (edge_n == deadline) begin
             if (req != 4'b0000) grant();
             else m_state = 1;
           end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got lv=%0b road=%0d light=%03b state=%0d active=%0d, expected lv=%0b road=%0d light=%03b state=%0d active=%0d",
                  name, act[10], act[9:8], act[7:5], act[4:2], act[1:0],
                  exp[10], exp[9:8], exp[7:5], exp[4:2], exp[1:0]);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    int         n;
    logic       lv;
    logic [1:0] rd;
    logic [2:0] lt;
    logic [2:0] st;
    logic [1:0] act;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] rq, input int n, input logic lv,
                     input logic [1:0] rd, input logic [2:0] lt, input logic [2:0] st,
                     input logic [1:0] act);
    vec_t v;
    v.rst = rst; v.rq = rq; v.n = n; v.lv = lv; v.rd = rd; v.lt = lt; v.st = st; v.act = act;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset and INIT red sweep
    add(1'b1, 4'b0000, 2, 1'b1, 2'd0, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd0, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b1, 2'd0, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd1, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b1, 2'd1, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd2, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b1, 2'd2, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd3, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 3, 1'b1, 2'd3, RED, 3'd1, 2'd0);
    // Two requesters: road 1 then road 3; then wrap to road 0
    add(1'b0, 4'b1010, 1, 1'b0, 2'd1, GRN, 3'd2, 2'd1);
    add(1'b0, 4'b1010, 7, 1'b1, 2'd1, GRN, 3'd2, 2'd1);
    add(1'b0, 4'b1010, 1, 1'b0, 2'd1, YEL, 3'd3, 2'd1);
    add(1'b0, 4'b1010, 2, 1'b1, 2'd1, YEL, 3'd3, 2'd1);
    add(1'b0, 4'b1010, 1, 1'b0, 2'd1, RED, 3'd4, 2'd1);
    add(1'b0, 4'b1010, 1, 1'b1, 2'd1, RED, 3'd4, 2'd1);
    add(1'b0, 4'b1010, 1, 1'b0, 2'd3, GRN, 3'd2, 2'd3);
    add(1'b0, 4'b0011, 7, 1'b1, 2'd3, GRN, 3'd2, 2'd3);
    add(1'b0, 4'b0011, 1, 1'b0, 2'd3, YEL, 3'd3, 2'd3);
    add(1'b0, 4'b0011, 2, 1'b1, 2'd3, YEL, 3'd3, 2'd3);
    add(1'b0, 4'b0011, 1, 1'b0, 2'd3, RED, 3'd4, 2'd3);
    add(1'b0, 4'b0011, 1, 1'b1, 2'd3, RED, 3'd4, 2'd3);
    add(1'b0, 4'b0011, 1, 1'b0, 2'd0, GRN, 3'd2, 2'd0);
    // Green extends without competing request; requests drop during clear
    add(1'b0, 4'b0000, 8, 1'b1, 2'd0, GRN, 3'd2, 2'd0);
    add(1'b0, 4'b0000, 7, 1'b1, 2'd0, GRN, 3'd2, 2'd0);
    add(1'b0, 4'b0010, 1, 1'b0, 2'd0, YEL, 3'd3, 2'd0);
    add(1'b0, 4'b0000, 2, 1'b1, 2'd0, YEL, 3'd3, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd0, RED, 3'd4, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b1, 2'd0, RED, 3'd4, 2'd0);
    add(1'b0, 4'b0000, 3, 1'b1, 2'd0, RED, 3'd1, 2'd0);
    // Single own request: green held across two expiries
    add(1'b0, 4'b0100, 1, 1'b0, 2'd2, GRN, 3'd2, 2'd2);
    add(1'b0, 4'b0100, 16, 1'b1, 2'd2, GRN, 3'd2, 2'd2);
    add(1'b0, 4'b0000, 7, 1'b1, 2'd2, GRN, 3'd2, 2'd2);
    add(1'b0, 4'b0001, 1, 1'b0, 2'd2, YEL, 3'd3, 2'd2);
    add(1'b0, 4'b0000, 2, 1'b1, 2'd2, YEL, 3'd3, 2'd2);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd2, RED, 3'd4, 2'd2);
    add(1'b0, 4'b0000, 1, 1'b1, 2'd2, RED, 3'd4, 2'd2);
    add(1'b0, 4'b0000, 4, 1'b1, 2'd2, RED, 3'd1, 2'd2);
    add(1'b0, 4'b0001, 1, 1'b0, 2'd0, GRN, 3'd2, 2'd0);
    add(1'b0, 4'b0001, 7, 1'b1, 2'd0, GRN, 3'd2, 2'd0);
    // Reset during yellow, then during INIT
    add(1'b0, 4'b0010, 1, 1'b0, 2'd0, YEL, 3'd3, 2'd0);
    add(1'b0, 4'b0010, 1, 1'b1, 2'd0, YEL, 3'd3, 2'd0);
    add(1'b1, 4'b0010, 1, 1'b1, 2'd0, RED, 3'd0, 2'd0);
    add(1'b1, 4'b0000, 1, 1'b1, 2'd0, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd0, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b1, 2'd0, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd1, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b1, 2'd1, RED, 3'd0, 2'd0);
    add(1'b1, 4'b0000, 1, 1'b1, 2'd0, RED, 3'd0, 2'd0);
    add(1'b0, 4'b0000, 1, 1'b0, 2'd0, RED, 3'd0, 2'd0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].rq;
      for (int j = 0; j < vecs[i].n; j++) begin
        step();
        check($sformatf("vec%0d.%0d", i, j),
              {light_valid, road, light_out, state, active_road},
              {vecs[i].lv, vecs[i].rd, vecs[i].lt, vecs[i].st, vecs[i].act});
      end
    end

    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 2) == 0) req = 4'b0000;
        else req = 4'($urandom_range(0, 15));
      end
      step();
      check($sformatf("rand%0d", c),
            {light_valid, road, light_out, state, active_road},
            {m_lv, 2'(m_road), m_light, 3'(m_state), 2'(m_active)});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
